atomic_counter_reader: RTL and testbench

- Initiator side of the two-beat atomic 64-bit counter read protocol.
- On a single-cycle start handshake it drives req/atomic towards the counter responder and captures the low word, then the high-word snapshot, from the 32-bit return bus.
- It presents the assembled 64-bit value with a valid pulse.
- It also checks for missing acks and non-monotonic readings, and keeps a saturating error count for debug.

---
 rtl/atomic_counters_pkg.sv | 10 +
 rtl/atomic_counter_reader.sv | 109 ++++++++++
 tb/tb_atomic_counter_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/atomic_counters_pkg.sv
// Shared types for the two-beat atomic 64-bit counter read protocol.
package atomic_counters_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, LAST} state_t;

  localparam int HALF_W_DEFAULT = 32;

  typedef logic [2*HALF_W_DEFAULT-1:0] read_word_t;

endpackage

// File: rtl/atomic_counter_reader.sv
// Initiator for the atomic counter read: issues the two-beat request, assembles
// the 64-bit value and flags missing acks and non-monotonic readings.
module atomic_counter_reader
  import atomic_counters_pkg::*;
#(
  parameter int HALF_W     = HALF_W_DEFAULT,
  parameter bit CHECK_MONO = 1'b1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_start_i,
  output logic                  rd_ready_o,
  output logic                  req_o,
  output logic                  atomic_o,
  input  logic                  ack_i,
  input  logic [HALF_W-1:0]     count_i,
  output logic                  rd_valid_o,
  output logic [2*HALF_W-1:0]   rd_data_o,
  output logic                  rd_err_o,
  output logic                  mono_err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam int W = 2*HALF_W;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   lo_q;
  logic                miss_q;
  logic [W-1:0]        last_q;

  logic [HALF_W-1:0]   hi_word;
  logic                read_miss;
  logic [W-1:0]        read_word;
  logic                read_mono;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start_i) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = LAST;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req stays high through HI so the responder keeps driving the bus for the high beat.
  always_comb begin
    rd_ready_o = 1'b0;
    req_o      = 1'b0;
    atomic_o   = 1'b0;
    case (state_q)
      IDLE:    rd_ready_o = 1'b1;
      LO: begin
        req_o    = 1'b1;
        atomic_o = 1'b1;
      end
      HI:      req_o = 1'b1;
      default: ;
    endcase
  end

  assign hi_word   = ack_i ? count_i : '0;
  assign read_miss = miss_q | ~ack_i;
  assign read_word = {hi_word, lo_q};
  assign read_mono = CHECK_MONO && !read_miss && (read_word < last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q       <= '0;
      miss_q     <= 1'b0;
      last_q     <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_err_o   <= 1'b0;
      mono_err_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      mono_err_o <= 1'b0;
      case (state_q)
        LO: miss_q <= 1'b0;
        HI: begin
          lo_q <= ack_i ? count_i : '0;
          if (!ack_i) miss_q <= 1'b1;
        end
        LAST: begin
          rd_data_o  <= read_word;
          rd_valid_o <= 1'b1;
          rd_err_o   <= read_miss;
          mono_err_o <= read_mono;
          // Error reads carry zeroed beats, so they must not become the reference.
          if (!read_miss) last_q <= read_word;
          if ((read_miss || read_mono) && err_cnt_o != ERR_MAX)
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Self-checking bench: a responder model feeds three reader instances
// (default, monotonic check off, 2-bit error counter) with shared stimulus.
module tb_atomic_counter_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_start_i;
  logic        ack_i;
  logic [31:0] count_i;

  logic        rd_ready_o, req_o, atomic_o, rd_valid_o, rd_err_o, mono_err_o;
  logic [63:0] rd_data_o;
  logic [7:0]  err_cnt_o;

  logic        nm_ready, nm_req, nm_atomic, nm_valid, nm_err, nm_mono;
  logic [63:0] nm_data;
  logic [7:0]  nm_cnt;

  logic        e2_ready, e2_req, e2_atomic, e2_valid, e2_err, e2_mono;
  logic [63:0] e2_data;
  logic [1:0]  e2_cnt;

  always #5 clk = ~clk;

  atomic_counter_reader dut (
    .clk(clk), .reset_n(reset_n), .rd_start_i(rd_start_i), .rd_ready_o(rd_ready_o),
    .req_o(req_o), .atomic_o(atomic_o), .ack_i(ack_i), .count_i(count_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
    .mono_err_o(mono_err_o), .err_cnt_o(err_cnt_o)
  );

  atomic_counter_reader #(.CHECK_MONO(1'b0)) dut_nm (
    .clk(clk), .reset_n(reset_n), .rd_start_i(rd_start_i), .rd_ready_o(nm_ready),
    .req_o(nm_req), .atomic_o(nm_atomic), .ack_i(ack_i), .count_i(count_i),
    .rd_valid_o(nm_valid), .rd_data_o(nm_data), .rd_err_o(nm_err),
    .mono_err_o(nm_mono), .err_cnt_o(nm_cnt)
  );

  atomic_counter_reader #(.ERR_CNT_W(2)) dut_e2 (
    .clk(clk), .reset_n(reset_n), .rd_start_i(rd_start_i), .rd_ready_o(e2_ready),
    .req_o(e2_req), .atomic_o(e2_atomic), .ack_i(ack_i), .count_i(count_i),
    .rd_valid_o(e2_valid), .rd_data_o(e2_data), .rd_err_o(e2_err),
    .mono_err_o(e2_mono), .err_cnt_o(e2_cnt)
  );

  // Responder: value snapshotted on req+atomic, low word then high word acked one cycle after req.
  logic [63:0] resp_val = '0;
  bit          drop_lo = 0, drop_hi = 0;
  logic [31:0] snap_hi = '0;
  bit          pend_snap = 0, pend_ack = 0;

  always @(negedge clk) begin
    pend_snap = req_o & atomic_o;
    pend_ack  = req_o;
  end

  always @(posedge clk) begin
    #1;
    if (pend_snap) begin
      snap_hi = resp_val[63:32];
      ack_i   = !drop_lo;
      count_i = drop_lo ? $urandom : resp_val[31:0];
    end else if (pend_ack) begin
      ack_i   = !drop_hi;
      count_i = drop_hi ? $urandom : snap_hi;
    end else begin
      ack_i   = 1'b0;
      count_i = $urandom;
    end
  end

  int total = 0;
  int bad = 0;
  int model_cnt = 0, nm_model = 0, e2_model = 0;
  logic [63:0] model_last = '0;

  typedef struct {
    logic [63:0] value;
    bit          dl;
    bit          dh;
    logic [63:0] exp_data;
    bit          exp_err;
    bit          exp_mono;
  } vec_t;

  vec_t table_v[10];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int c, input int max);
    return (c >= max) ? max : c + 1;
  endfunction

  // Called at a negedge; returns at the negedge of the valid cycle.
  task automatic apply_stimulus(input logic [63:0] value, input bit dl, input bit dh,
                                input logic [63:0] exp_data, input bit exp_err, input bit exp_mono);
    resp_val   = value;
    drop_lo    = dl;
    drop_hi    = dh;
    rd_start_i = 1'b1;
    @(negedge clk);
    rd_start_i = 1'b0;
    check_output("lo_req_atomic", {req_o, atomic_o}, 2'b11);
    check_output("lo_ready", rd_ready_o, 0);
    @(negedge clk);
    check_output("hi_req_atomic", {req_o, atomic_o}, 2'b10);
    check_output("hi_ready", rd_ready_o, 0);
    @(negedge clk);
    check_output("last_req_atomic", {req_o, atomic_o}, 2'b00);
    check_output("last_valid_early", rd_valid_o, 0);
    @(negedge clk);
    if (exp_err || exp_mono) model_cnt = sat_inc(model_cnt, 255);
    if (exp_err || exp_mono) e2_model = sat_inc(e2_model, 3);
    if (exp_err) nm_model = sat_inc(nm_model, 255);
    if (!exp_err) model_last = exp_data;
    check_output("valid", rd_valid_o, 1);
    check_output("ready_back", rd_ready_o, 1);
    check_output("data", rd_data_o, exp_data);
    check_output("rd_err", rd_err_o, exp_err);
    check_output("mono_err", mono_err_o, exp_mono);
    check_output("err_cnt", err_cnt_o, model_cnt);
    check_output("nm_mono", nm_mono, 0);
    check_output("nm_err_cnt", nm_cnt, nm_model);
    check_output("e2_err_cnt", e2_cnt, e2_model);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] v, ed;
    bit dl, dh, ee, em;

    table_v[0] = '{64'h0000_0005_FFFF_FFF0, 0, 0, 64'h0000_0005_FFFF_FFF0, 0, 0};
    table_v[1] = '{64'h0000_0005_FFFF_FFF0, 1, 0, 64'h0000_0005_0000_0000, 1, 0};
    table_v[2] = '{64'h0000_0005_8000_0000, 0, 0, 64'h0000_0005_8000_0000, 0, 1};
    table_v[3] = '{64'h0000_0000_0000_0010, 0, 0, 64'h0000_0000_0000_0010, 0, 1};
    table_v[4] = '{64'h0000_0000_0000_000F, 0, 0, 64'h0000_0000_0000_000F, 0, 1};
    table_v[5] = '{64'h0000_0123_0000_0042, 0, 1, 64'h0000_0000_0000_0042, 1, 0};
    table_v[6] = '{64'h0000_0000_0000_000F, 0, 0, 64'h0000_0000_0000_000F, 0, 0};
    table_v[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0000_0000_0000_0000, 1, 0};
    table_v[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    table_v[9] = '{64'h0000_0000_0000_0000, 0, 0, 64'h0000_0000_0000_0000, 0, 1};

    reset_n    = 1'b0;
    rd_start_i = 1'b0;
    ack_i      = 1'b0;
    count_i    = '0;
    repeat (3) @(negedge clk);
    check_output("rst_req_atomic", {req_o, atomic_o}, 2'b00);
    check_output("rst_valid", rd_valid_o, 0);
    check_output("rst_data", rd_data_o, 0);
    check_output("rst_errs", {rd_err_o, mono_err_o}, 0);
    check_output("rst_err_cnt", err_cnt_o, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", rd_ready_o, 1);

    for (int i = 0; i < 10; i++)
      apply_stimulus(table_v[i].value, table_v[i].dl, table_v[i].dh,
                     table_v[i].exp_data, table_v[i].exp_err, table_v[i].exp_mono);

    // Start held high: reads back-to-back every 4 cycles.
    resp_val   = 64'h100;
    drop_lo    = 0;
    drop_hi    = 0;
    rd_start_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_output("hold_ready", rd_ready_o, (c % 4) == 0);
      check_output("hold_valid", rd_valid_o, (c % 4) == 0);
      if ((c % 4) == 0) begin
        check_output("hold_data", rd_data_o, 64'h100);
        check_output("hold_mono", mono_err_o, 0);
      end
    end
    rd_start_i = 1'b0;
    model_last = 64'h100;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1)
        v = model_last - 64'($urandom_range(8, 0)) + 64'($urandom_range(8, 0));
      else
        v = {$urandom, $urandom};
      dl = ($urandom_range(3, 0) == 0);
      dh = ($urandom_range(3, 0) == 0);
      ed = {dh ? 32'h0 : v[63:32], dl ? 32'h0 : v[31:0]};
      ee = dl || dh;
      em = !ee && (ed < model_last);
      apply_stimulus(v, dl, dh, ed, ee, em);
    end

    // Reset during HI abandons the read.
    resp_val   = 64'h55;
    rd_start_i = 1'b1;
    @(negedge clk);
    rd_start_i = 1'b0;
    @(negedge clk);
    check_output("pre_reset_hi", {req_o, atomic_o}, 2'b10);
    reset_n = 1'b0;
    #1;
    check_output("midrst_req_atomic", {req_o, atomic_o}, 2'b00);
    check_output("midrst_valid", rd_valid_o, 0);
    check_output("midrst_data", rd_data_o, 0);
    check_output("midrst_err_cnt", err_cnt_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_cnt = 0; nm_model = 0; e2_model = 0; model_last = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("no_valid_after_reset", rd_valid_o, 0);
    end
    apply_stimulus(64'h7, 0, 0, 64'h7, 0, 0);

    for (int n = 0; n < 5; n++) begin
      v = {$urandom, $urandom};
      apply_stimulus(v, 1, 0, {v[63:32], 32'h0}, 1, 0);
    end
    check_output("e2_saturated", e2_cnt, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
